c4_move_sender: RTL and testbench

//   Host-side driver for the Connect4 chip's 12-bit input bus. Accepts game commands
//   (move in column 0-6, switch player, switch PvP, new game, toggle debug) over a

---
 rtl/c4_move_sender.sv | 187 ++++++++++++++++++
 tb/tb_c4_move_sender.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/c4_move_sender.sv
// Host-side sequencer for the Connect4 chip's 12-bit io_in bus: accepts one game
// command per handshake and plays it out with fixed setup/strobe/hold/gap timing.
module c4_move_sender #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_col,
  output logic [11:0] io_drv,
  output logic        busy,
  output logic        cmd_err
);

  localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_HG = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_P  = (MAX_SP > MAX_HG) ? MAX_SP : MAX_HG;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);

  localparam logic [2:0]  OP_MOVE     = 3'd0;
  localparam logic [2:0]  OP_LAST     = 3'd4;
  localparam logic [2:0]  COL_ILLEGAL = 3'd7;
  localparam logic [11:0] CONFIRM_BIT = 12'h080;
  localparam logic [11:0] BUS_IDLE    = 12'h000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    op_r;
  logic [2:0]    col_r;
  logic          cmd_legal_s;
  logic          cnt_zero_s;

  // Column one-hot on bits [6:0]; column 7 has no bus encoding.
  function automatic logic [11:0] col_bits(input logic [2:0] col);
    logic [11:0] bits;
    case (col)
      3'd0:    bits = 12'h001;
      3'd1:    bits = 12'h002;
      3'd2:    bits = 12'h004;
      3'd3:    bits = 12'h008;
      3'd4:    bits = 12'h010;
      3'd5:    bits = 12'h020;
      3'd6:    bits = 12'h040;
      default: bits = 12'h000;
    endcase
    return bits;
  endfunction

  // Single command strobe bit for the non-move ops (bit 7+op).
  function automatic logic [11:0] op_bits(input logic [2:0] op);
    logic [11:0] bits;
    case (op)
      3'd1:    bits = 12'h100;
      3'd2:    bits = 12'h200;
      3'd3:    bits = 12'h400;
      3'd4:    bits = 12'h800;
      default: bits = 12'h000;
    endcase
    return bits;
  endfunction

  assign cmd_ready  = (state_r == IDLE) & ~reset;
  assign cnt_zero_s = (cnt_r == CNT_ZERO);

  // Legality check of the offered command: ops 5-7 and a move into column 7 are rejected.
  always_comb begin
    cmd_legal_s = 1'b0;
    if (cmd_op == OP_MOVE) begin
      cmd_legal_s = (cmd_col != COL_ILLEGAL);
    end else if (cmd_op <= OP_LAST) begin
      cmd_legal_s = 1'b1;
    end else begin
      cmd_legal_s = 1'b0;
    end
  end

  // Sequencer FSM with registered bus, busy and error outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      op_r    <= OP_MOVE;
      col_r   <= 3'd0;
      io_drv  <= BUS_IDLE;
      busy    <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_legal_s) begin
              op_r  <= cmd_op;
              col_r <= cmd_col;
              busy  <= 1'b1;
              if (cmd_op == OP_MOVE) begin
                state_r <= SETUP;
                cnt_r   <= SETUP_LD;
                io_drv  <= col_bits(cmd_col);
              end else begin
                state_r <= STROBE;
                cnt_r   <= PULSE_LD;
                io_drv  <= op_bits(cmd_op);
              end
            end else begin
              // Dropped command: flag it, stay idle with a quiet bus.
              cmd_err <= 1'b1;
              busy    <= 1'b0;
              io_drv  <= BUS_IDLE;
            end
          end else begin
            busy   <= 1'b0;
            io_drv <= BUS_IDLE;
          end
        end
        SETUP: begin
          if (cnt_zero_s) begin
            state_r <= STROBE;
            cnt_r   <= PULSE_LD;
            io_drv  <= col_bits(col_r) | CONFIRM_BIT;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        STROBE: begin
          if (cnt_zero_s) begin
            if (op_r == OP_MOVE) begin
              state_r <= HOLD;
              cnt_r   <= HOLD_LD;
              io_drv  <= col_bits(col_r);
            end else begin
              state_r <= GAP;
              cnt_r   <= GAP_LD;
              io_drv  <= BUS_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt_zero_s) begin
            state_r <= GAP;
            cnt_r   <= GAP_LD;
            io_drv  <= BUS_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        GAP: begin
          if (cnt_zero_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
          io_drv  <= BUS_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c4_move_sender.sv
// Directed bench for c4_move_sender: a default-timing instance and a PULSE=1/GAP=1
// instance share the command inputs and are checked cycle by cycle.
module tb_c4_move_sender;

  localparam int S1 = 2, P1 = 3, H1 = 2, G1 = 4;
  localparam int S2 = 2, P2 = 1, H2 = 2, G2 = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_col;
  logic        rdy1, busy1, err1;
  logic        rdy2, busy2, err2;
  logic [11:0] io1, io2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  c4_move_sender #(.SETUP_CYC(S1), .PULSE_CYC(P1), .HOLD_CYC(H1), .GAP_CYC(G1)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
    .cmd_op(cmd_op), .cmd_col(cmd_col), .io_drv(io1), .busy(busy1), .cmd_err(err1));

  c4_move_sender #(.SETUP_CYC(S2), .PULSE_CYC(P2), .HOLD_CYC(H2), .GAP_CYC(G2)) dut2 (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy2),
    .cmd_op(cmd_op), .cmd_col(cmd_col), .io_drv(io2), .busy(busy2), .cmd_err(err2));

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  col;
    logic        err;
    logic [11:0] colb;
    logic [11:0] strb;
    int          occ1;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int k, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (k=%0d): got 0x%03h, expected 0x%03h", name, k, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_io(input logic mv, input logic [11:0] colb,
                                         input logic [11:0] strb, input int k,
                                         input int s, input int p, input int h);
    if (mv) begin
      if (k <= s) return colb;
      else if (k <= s + p) return strb;
      else if (k <= s + p + h) return colb;
      else return 12'h000;
    end else begin
      if (k <= p) return strb;
      else return 12'h000;
    end
  endfunction

  function automatic int occ_of(input logic mv, input int s, input int p, input int h, input int g);
    return mv ? (1 + s + p + h + g) : (1 + p + g);
  endfunction

  function automatic logic inv_ok(input logic [11:0] v);
    logic ok;
    ok = 1'b1;
    if ($countones(v[6:0]) > 1) ok = 1'b0;
    if (v[7] && (v[6:0] == 7'd0)) ok = 1'b0;
    if ($countones(v[11:7]) > 1) ok = 1'b0;
    if ((v[11:8] != 4'd0) && (v[7:0] != 8'd0)) ok = 1'b0;
    return ok;
  endfunction

  task automatic wait_idle();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if (rdy1 && rdy2) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: ready %0b/%0b, expected 1/1", rdy1, rdy2);
    end
  endtask

  // Issue one command to both instances and check every cycle until both are idle again.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] col, input logic err,
                         input logic [11:0] colb, input logic [11:0] strb, input int occ1);
    logic mv;
    int   occ2;
    logic [11:0] e1, e2;
    mv   = (op == 3'd0) && !err;
    occ2 = err ? 1 : occ_of(mv, S2, P2, H2, G2);
    wait_idle();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_col   = col;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_col   = 3'd7;
    for (int k = 1; k <= occ1 + 1; k++) begin
      @(negedge clock);
      e1 = (err || k >= occ1) ? 12'h000 : exp_io(mv, colb, strb, k, S1, P1, H1);
      e2 = (err || k >= occ2) ? 12'h000 : exp_io(mv, colb, strb, k, S2, P2, H2);
      chk("io1", k, io1, e1);
      chk("io2", k, io2, e2);
      chk("busy1", k, {11'd0, busy1}, {11'd0, !err && k < occ1});
      chk("busy2", k, {11'd0, busy2}, {11'd0, !err && k < occ2});
      chk("ready1", k, {11'd0, rdy1}, {11'd0, err || k >= occ1});
      chk("ready2", k, {11'd0, rdy2}, {11'd0, err || k >= occ2});
      chk("err1", k, {11'd0, err1}, {11'd0, err && k == 1});
      chk("err2", k, {11'd0, err2}, {11'd0, err && k == 1});
      chk("inv1", k, {11'd0, inv_ok(io1)}, 12'h001);
      // A busy-time offer carrying a different op must be ignored by both instances.
      if (k == 2 && !err) begin
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_col   = 3'd5;
      end
      if (k == 3) cmd_valid = 1'b0;
    end
  endtask

  initial begin
    logic [2:0]  rop, rcol;
    logic        rerr;
    logic [11:0] rcolb, rstrb;
    logic [11:0] e1;

    vecs[0]  = '{3'd0, 3'd3, 1'b0, 12'h008, 12'h088, 12};
    vecs[1]  = '{3'd0, 3'd0, 1'b0, 12'h001, 12'h081, 12};
    vecs[2]  = '{3'd0, 3'd6, 1'b0, 12'h040, 12'h0C0, 12};
    vecs[3]  = '{3'd0, 3'd7, 1'b1, 12'h000, 12'h000, 1};
    vecs[4]  = '{3'd1, 3'd2, 1'b0, 12'h000, 12'h100, 8};
    vecs[5]  = '{3'd2, 3'd0, 1'b0, 12'h000, 12'h200, 8};
    vecs[6]  = '{3'd3, 3'd7, 1'b0, 12'h000, 12'h400, 8};
    vecs[7]  = '{3'd4, 3'd1, 1'b0, 12'h000, 12'h800, 8};
    vecs[8]  = '{3'd5, 3'd0, 1'b1, 12'h000, 12'h000, 1};
    vecs[9]  = '{3'd6, 3'd3, 1'b1, 12'h000, 12'h000, 1};
    vecs[10] = '{3'd7, 3'd6, 1'b1, 12'h000, 12'h000, 1};
    vecs[11] = '{3'd0, 3'd5, 1'b0, 12'h020, 12'h0A0, 12};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_col   = 3'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready1", 0, {11'd0, rdy1}, 12'h000);
    chk("rst_ready2", 0, {11'd0, rdy2}, 12'h000);
    chk("rst_io1", 0, io1, 12'h000);
    chk("rst_busy1", 0, {11'd0, busy1}, 12'h000);
    chk("rst_err1", 0, {11'd0, err1}, 12'h000);
    reset = 1'b0;
    #1;
    chk("post_rst_ready1", 0, {11'd0, rdy1}, 12'h001);

    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i].op, vecs[i].col, vecs[i].err, vecs[i].colb, vecs[i].strb, vecs[i].occ1);
    end

    // Back-to-back: MOVE col 0 then SWITCH_PVP, valid held the whole time.
    wait_idle();
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_col   = 3'd0;
    @(posedge clock);
    #1;
    cmd_op  = 3'd2;
    cmd_col = 3'd7;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k < 12) e1 = exp_io(1'b1, 12'h001, 12'h081, k, S1, P1, H1);
      else if (k == 12 || k == 20) e1 = 12'h000;
      else e1 = exp_io(1'b0, 12'h000, 12'h200, k - 12, S1, P1, H1);
      chk("b2b_io", k, io1, e1);
      chk("b2b_ready", k, {11'd0, rdy1}, {11'd0, k == 12 || k == 20});
      chk("b2b_busy", k, {11'd0, busy1}, {11'd0, k != 12 && k != 20});
      chk("b2b_inv1", k, {11'd0, inv_ok(io1)}, 12'h001);
      chk("b2b_inv2", k, {11'd0, inv_ok(io2)}, 12'h001);
      if (k == 13) cmd_valid = 1'b0;
    end

    // Reset in the middle of a MOVE col 6 strobe.
    wait_idle();
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    cmd_col   = 3'd6;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("mid_strobe_io", 3, io1, 12'h0C0);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_io1", 4, io1, 12'h000);
    chk("abort_io2", 4, io2, 12'h000);
    chk("abort_busy1", 4, {11'd0, busy1}, 12'h000);
    chk("abort_ready1", 4, {11'd0, rdy1}, 12'h000);
    reset = 1'b0;
    #1;
    chk("abort_rel_ready1", 4, {11'd0, rdy1}, 12'h001);
    chk("abort_rel_ready2", 4, {11'd0, rdy2}, 12'h001);
    run_cmd(3'd0, 3'd2, 1'b0, 12'h004, 12'h084, 12);

    // Mixed legal/illegal stream; expected encodings come from a small bus model.
    for (int n = 0; n < 20; n++) begin
      rop   = 3'($urandom_range(0, 7));
      rcol  = 3'($urandom_range(0, 7));
      rerr  = (rop > 3'd4) || (rop == 3'd0 && rcol == 3'd7);
      rcolb = (rop == 3'd0 && !rerr) ? (12'h001 << rcol) : 12'h000;
      if (rerr) rstrb = 12'h000;
      else if (rop == 3'd0) rstrb = rcolb | 12'h080;
      else rstrb = 12'h001 << (7 + rop);
      run_cmd(rop, rcol, rerr, rcolb, rstrb, rerr ? 1 : (rop == 3'd0 ? 12 : 8));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
